// File: rtl/mem_stage.sv
// mem_stage: memory stage of the five-stage pipeline with the MEM/WB register.
// Issues word loads/stores over a req/ack handshake and freezes upstream while busy.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   WB_EN, MEM_R_EN,  EXE results: register write, load, store,
//   MEM_W_EN, ALU_Res,  byte address or ALU result, store data,
//   Val_Rm, Dest        destination register
//   mem_req, mem_we,  registered request to word memory
//   mem_addr, mem_wdata
//   mem_ack, mem_rdata  completion strobe and load data from memory
//   Mem_Stall         combinational freeze for PC/IF/ID/EXE
//   WB_EN_out, MEM_R_EN_out, ALU_Res_out, Mem_Data, Dest_out  MEM/WB register

module mem_stage #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter int unsigned ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WB_EN,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_Res,
    input  logic [31:0]       Val_Rm,
    input  logic [3:0]        Dest,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              Mem_Stall,
    output logic              WB_EN_out,
    output logic              MEM_R_EN_out,
    output logic [31:0]       ALU_Res_out,
    output logic [31:0]       Mem_Data,
    output logic [3:0]        Dest_out
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic [31:0] alu_res;
        logic [3:0]  dest;
    } exe_lat_t;

    state_t   state;
    state_t   state_nxt;
    exe_lat_t lat;

    logic        access;
    logic [31:0] offset;
    logic        addr_unused;

    assign access = MEM_R_EN | MEM_W_EN;
    assign offset = ALU_Res - BASE_ADDR;

    // Byte offset bits and bits beyond the word address are dropped.
    assign addr_unused = ^{offset[31:ADDR_W+2], offset[1:0]};

    always_comb begin
        state_nxt = state;
        Mem_Stall = 1'b0;
        if (rst_n) begin
            unique case (state)
                IDLE: begin
                    Mem_Stall = access;
                    if (access) state_nxt = BUSY;
                end
                BUSY: begin
                    Mem_Stall = !mem_ack;
                    if (mem_ack) state_nxt = IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            lat          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            WB_EN_out    <= 1'b0;
            MEM_R_EN_out <= 1'b0;
            ALU_Res_out  <= '0;
            Mem_Data     <= '0;
            Dest_out     <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (access) begin
                        // A store wins over a simultaneous load.
                        lat <= '{
                            wb_en:    WB_EN,
                            mem_r_en: MEM_R_EN & ~MEM_W_EN,
                            alu_res:  ALU_Res,
                            dest:     Dest
                        };
                        mem_req      <= 1'b1;
                        mem_we       <= MEM_W_EN;
                        mem_addr     <= offset[ADDR_W+1:2];
                        mem_wdata    <= Val_Rm;
                        WB_EN_out    <= 1'b0;
                        MEM_R_EN_out <= 1'b0;
                        ALU_Res_out  <= '0;
                        Mem_Data     <= '0;
                        Dest_out     <= '0;
                    end else begin
                        WB_EN_out    <= WB_EN;
                        MEM_R_EN_out <= 1'b0;
                        ALU_Res_out  <= ALU_Res;
                        Mem_Data     <= '0;
                        Dest_out     <= Dest;
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        mem_req      <= 1'b0;
                        WB_EN_out    <= lat.wb_en;
                        MEM_R_EN_out <= lat.mem_r_en;
                        ALU_Res_out  <= lat.alu_res;
                        Mem_Data     <= lat.mem_r_en ? mem_rdata : 32'd0;
                        Dest_out     <= lat.dest;
                    end else begin
                        WB_EN_out    <= 1'b0;
                        MEM_R_EN_out <= 1'b0;
                        ALU_Res_out  <= '0;
                        Mem_Data     <= '0;
                        Dest_out     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized bench for mem_stage against a transaction-level model.
// The model holds a word memory array and predicts requests, stalls and write-back.

module tb_mem_stage;

    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] ALU_Res, Val_Rm;
    logic [3:0]  Dest;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        Mem_Stall;
    logic        WB_EN_out, MEM_R_EN_out;
    logic [31:0] ALU_Res_out, Mem_Data;
    logic [3:0]  Dest_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem_model [logic [15:0]];

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .Mem_Stall(Mem_Stall),
        .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
        .ALU_Res_out(ALU_Res_out), .Mem_Data(Mem_Data),
        .Dest_out(Dest_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {~a, a};
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_wb_zero(input string tag);
        chk({tag, "_wb"}, WB_EN_out, 0);
        chk({tag, "_rd"}, MEM_R_EN_out, 0);
        chk({tag, "_alu"}, ALU_Res_out, 0);
        chk({tag, "_data"}, Mem_Data, 0);
        chk({tag, "_dest"}, Dest_out, 0);
    endtask

    task automatic check_mem_zero(input string tag);
        chk({tag, "_req"}, mem_req, 0);
        chk({tag, "_we"}, mem_we, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
    endtask

    task automatic drive_idle();
        WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0;
        ALU_Res = 0; Val_Rm = 0; Dest = 0;
        mem_ack = 0; mem_rdata = 0;
    endtask

    // One instruction through the stage, starting and ending at a negedge
    // with the stage idle. k = ack delay in BUSY cycles.
    task automatic run_instr(input logic wb, input logic rd, input logic wr,
                             input logic [31:0] alu, input logic [31:0] rm,
                             input logic [3:0] dest, input int k,
                             input logic ack_idle);
        logic        acc;
        logic        is_load;
        logic [31:0] off;
        logic [15:0] ea;
        logic [31:0] ed;
        int          stalls;
        acc     = rd | wr;
        is_load = rd & !wr;
        off     = alu - BASE;
        ea      = 16'((off / 4) % 65536);
        stalls  = 0;

        WB_EN = wb; MEM_R_EN = rd; MEM_W_EN = wr;
        ALU_Res = alu; Val_Rm = rm; Dest = dest;
        mem_ack = ack_idle; mem_rdata = $urandom;
        #1;
        chk("stall_idle", Mem_Stall, acc);
        if (Mem_Stall) stalls++;
        cyc();
        mem_ack = 0;

        if (acc) begin
            for (int i = 0; i <= k; i++) begin
                chk("req_high", mem_req, 1);
                chk("addr", mem_addr, ea);
                chk("we", mem_we, wr);
                if (wr) chk("wdata", mem_wdata, rm);
                chk("bubble_wb", WB_EN_out, 0);
                chk("bubble_rd", MEM_R_EN_out, 0);
                // EXE inputs must be ignored while busy.
                WB_EN = 1'($urandom); MEM_R_EN = 1'($urandom);
                MEM_W_EN = 1'($urandom); ALU_Res = $urandom;
                Val_Rm = $urandom; Dest = 4'($urandom);
                mem_ack = (i == k);
                mem_rdata = (i == k && !mem_we) ? model_read(mem_addr)
                                                : $urandom;
                #1;
                chk("stall_busy", Mem_Stall, i != k);
                if (Mem_Stall) stalls++;
                cyc();
            end
            mem_ack = 0;
            if (wr) mem_model[ea] = rm;
        end

        ed = is_load ? model_read(ea) : 32'd0;
        chk("req_low", mem_req, 0);
        chk("wb_en", WB_EN_out, wb);
        chk("wb_rd", MEM_R_EN_out, acc ? is_load : 1'b0);
        chk("wb_alu", ALU_Res_out, alu);
        chk("wb_data", Mem_Data, ed);
        chk("wb_dest", Dest_out, dest);
        chk("stall_cnt", stalls, acc ? k + 1 : 0);
    endtask

    initial begin
        drive_idle();
        MEM_R_EN = 1; MEM_W_EN = 1;
        rst_n = 0;
        @(negedge clk);
        #1;
        chk("rst_stall", Mem_Stall, 0);
        cyc();
        cyc();
        check_mem_zero("rst");
        check_wb_zero("rst");
        drive_idle();
        rst_n = 1;
        cyc();

        // ALU passthrough
        run_instr(1, 0, 0, 32'h7, 32'h0, 4'd3, 0, 0);
        // Load, ack after 3 BUSY cycles
        mem_model[16'd2] = 32'hDEAD_BEEF;
        run_instr(1, 1, 0, 32'd1032, 32'h0, 4'd5, 3, 0);
        run_instr(0, 0, 0, 32'h0, 32'h0, 4'd0, 0, 0);
        // Store, immediate ack
        run_instr(0, 0, 1, 32'd1028, 32'h1234_5678, 4'd9, 0, 0);
        // Back-to-back loads
        run_instr(1, 1, 0, 32'd1024, 32'h0, 4'd1, 0, 0);
        run_instr(1, 1, 0, 32'd1040, 32'h0, 4'd2, 0, 0);
        // Wrapped address, dual enable, ack in IDLE
        run_instr(1, 1, 0, 32'd1000, 32'h0, 4'd6, 1, 0);
        run_instr(1, 1, 1, 32'd1100, 32'hCAFE_F00D, 4'd7, 2, 0);
        run_instr(1, 1, 0, 32'd1100, 32'h0, 4'd8, 0, 0);
        run_instr(0, 0, 0, 32'h55, 32'h0, 4'd4, 0, 1);

        // Reset mid-access
        WB_EN = 1; MEM_R_EN = 1; MEM_W_EN = 0;
        ALU_Res = 32'd1048; Dest = 4'd10;
        cyc();
        chk("mid_req", mem_req, 1);
        rst_n = 0;
        #1;
        chk("mid_stall", Mem_Stall, 0);
        cyc();
        check_mem_zero("mid_rst");
        check_wb_zero("mid_rst");
        drive_idle();
        rst_n = 1;
        mem_ack = 1;
        mem_rdata = 32'hBAD0_BAD0;
        #1;
        chk("late_ack_stall", Mem_Stall, 0);
        cyc();
        mem_ack = 0;
        chk("late_ack_req", mem_req, 0);
        check_wb_zero("late_ack");

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 7);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = BASE + $urandom_range(0, 63) * 4 + $urandom_range(0, 3);
            run_instr(1'($urandom),
                      kind inside {[3:4], 7},
                      kind inside {[5:7]},
                      a, $urandom, 4'($urandom),
                      $urandom_range(0, 4), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
